// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS systolic matrix multiplier.
// C[r][c] = sum_k A[r][k]*B[k][c]. Operands are skewed internally and the
// array is flushed by a control FSM. Results then drain one row per beat.
// Optional build macro SYSTOLIC_SAT_EN: saturating, sticky accumulators.
// Without the macro, accumulators wrap in two's complement.
module systolic_array_os #(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int KW    = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [KW-1:0]                            k_len,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [ROWS*W-1:0]                        a_in,
  input  logic [COLS*W-1:0]                        b_in,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [COLS*ACC_W-1:0]                    out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic                                     busy,
  output logic                                     done
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int NFL = ROWS + COLS - 1;
  localparam int FW  = $clog2(NFL + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_cnt_q, k_cnt_d;
  logic [FW-1:0]  fl_cnt_q, fl_cnt_d;
  logic [RW-1:0]  out_row_q, out_row_d;
  logic           done_q, done_d;
  logic           clr_acc_s, adv_s, beat_s, acc_en_s;

  logic signed [W-1:0]     a_edge_s [ROWS];
  logic                    a_edge_v_s [ROWS];
  logic signed [W-1:0]     b_edge_s [COLS];
  logic                    b_edge_v_s [COLS];
  logic signed [W-1:0]     a_q [ROWS][COLS];
  logic signed [W-1:0]     b_q [ROWS][COLS];
  logic                    va_q [ROWS][COLS];
  logic                    vb_q [ROWS][COLS];
  logic signed [W-1:0]     pe_a_s [ROWS][COLS];
  logic signed [W-1:0]     pe_b_s [ROWS][COLS];
  logic                    pe_va_s [ROWS][COLS];
  logic                    pe_vb_s [ROWS][COLS];
  logic signed [ACC_W-1:0] acc_q [ROWS][COLS];
  logic signed [ACC_W-1:0] acc_sum_s [ROWS][COLS];

  // Full 2W-bit signed product, sign-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] prod_f(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    return ACC_W'(p);
  endfunction

`ifdef SYSTOLIC_SAT_EN
  logic sat_q [ROWS][COLS];
  logic ovf_s [ROWS][COLS];

  // Returns {overflow, clamped sum}; overflow when both addends share a sign
  // that the raw sum does not.
  function automatic logic [ACC_W:0] sat_add_f(input logic signed [ACC_W-1:0] acc,
                                               input logic signed [ACC_W-1:0] p);
    logic signed [ACC_W-1:0] s;
    logic                    ovf;
    s   = acc + p;
    ovf = (acc[ACC_W-1] == p[ACC_W-1]) && (s[ACC_W-1] != acc[ACC_W-1]);
    if (ovf) begin
      s = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      s = s;
    end
    return {ovf, s};
  endfunction
`endif

  assign adv_s    = (state_q != S_IDLE);
  assign beat_s   = (state_q == S_LOAD) && in_valid;
  assign acc_en_s = (state_q == S_LOAD) || (state_q == S_FLUSH);

  // A skew: row r is delayed r cycles; idle cycles inject zero with a low tag.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_askew
    logic signed [W-1:0] a_inj_s;
    assign a_inj_s = beat_s ? a_in[gr*W +: W] : '0;
    if (gr == 0) begin : g_direct
      assign a_edge_s[gr]   = a_inj_s;
      assign a_edge_v_s[gr] = beat_s;
    end else begin : g_dl
      logic signed [W-1:0] dl_q [gr];
      logic                dl_v_q [gr];
      // Shift the operand and its tag one stage per active cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < gr; i++) begin
            dl_q[i]   <= '0;
            dl_v_q[i] <= 1'b0;
          end
        end else if (adv_s) begin
          dl_q[0]   <= a_inj_s;
          dl_v_q[0] <= beat_s;
          for (int i = 1; i < gr; i++) begin
            dl_q[i]   <= dl_q[i-1];
            dl_v_q[i] <= dl_v_q[i-1];
          end
        end
      end
      assign a_edge_s[gr]   = dl_q[gr-1];
      assign a_edge_v_s[gr] = dl_v_q[gr-1];
    end
  end

  // B skew: column c is delayed c cycles.
  for (genvar gc = 0; gc < COLS; gc++) begin : g_bskew
    logic signed [W-1:0] b_inj_s;
    assign b_inj_s = beat_s ? b_in[gc*W +: W] : '0;
    if (gc == 0) begin : g_direct
      assign b_edge_s[gc]   = b_inj_s;
      assign b_edge_v_s[gc] = beat_s;
    end else begin : g_dl
      logic signed [W-1:0] dl_q [gc];
      logic                dl_v_q [gc];
      // Shift the operand and its tag one stage per active cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < gc; i++) begin
            dl_q[i]   <= '0;
            dl_v_q[i] <= 1'b0;
          end
        end else if (adv_s) begin
          dl_q[0]   <= b_inj_s;
          dl_v_q[0] <= beat_s;
          for (int i = 1; i < gc; i++) begin
            dl_q[i]   <= dl_q[i-1];
            dl_v_q[i] <= dl_v_q[i-1];
          end
        end
      end
      assign b_edge_s[gc]   = dl_q[gc-1];
      assign b_edge_v_s[gc] = dl_v_q[gc-1];
    end
  end

  // PE operand inputs: west edge / east-moving register for a, north edge / south-moving for b.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      pe_a_s[r][0]  = a_edge_s[r];
      pe_va_s[r][0] = a_edge_v_s[r];
      for (int c = 1; c < COLS; c++) begin
        pe_a_s[r][c]  = a_q[r][c-1];
        pe_va_s[r][c] = va_q[r][c-1];
      end
    end
    for (int c = 0; c < COLS; c++) begin
      pe_b_s[0][c]  = b_edge_s[c];
      pe_vb_s[0][c] = b_edge_v_s[c];
      for (int r = 1; r < ROWS; r++) begin
        pe_b_s[r][c]  = b_q[r-1][c];
        pe_vb_s[r][c] = vb_q[r-1][c];
      end
    end
  end

  // Candidate accumulator value for every PE.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
`ifdef SYSTOLIC_SAT_EN
        {ovf_s[r][c], acc_sum_s[r][c]} = sat_add_f(acc_q[r][c], prod_f(pe_a_s[r][c], pe_b_s[r][c]));
`else
        acc_sum_s[r][c] = acc_q[r][c] + prod_f(pe_a_s[r][c], pe_b_s[r][c]);
`endif
      end
    end
  end

  // PE registers: operands move every active cycle; tagged products accumulate in LOAD/FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
          va_q[r][c]  <= 1'b0;
          vb_q[r][c]  <= 1'b0;
          acc_q[r][c] <= '0;
`ifdef SYSTOLIC_SAT_EN
          sat_q[r][c] <= 1'b0;
`endif
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (adv_s) begin
            a_q[r][c]  <= pe_a_s[r][c];
            b_q[r][c]  <= pe_b_s[r][c];
            va_q[r][c] <= pe_va_s[r][c];
            vb_q[r][c] <= pe_vb_s[r][c];
          end
          if (clr_acc_s) begin
            acc_q[r][c] <= '0;
`ifdef SYSTOLIC_SAT_EN
            sat_q[r][c] <= 1'b0;
`endif
          end else if (acc_en_s && pe_va_s[r][c] && pe_vb_s[r][c]) begin
`ifdef SYSTOLIC_SAT_EN
            if (!sat_q[r][c]) begin
              acc_q[r][c] <= acc_sum_s[r][c];
              sat_q[r][c] <= ovf_s[r][c];
            end
`else
            acc_q[r][c] <= acc_sum_s[r][c];
`endif
          end
        end
      end
    end
  end

  // Control state and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_cnt_q   <= '0;
      fl_cnt_q  <= '0;
      out_row_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_cnt_q   <= k_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
      out_row_q <= out_row_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: IDLE -> LOAD (or FLUSH when k_len is 0) -> FLUSH -> DRAIN -> IDLE.
  always_comb begin
    state_d   = state_q;
    k_cnt_d   = k_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    out_row_d = out_row_q;
    done_d    = 1'b0;
    clr_acc_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clr_acc_s = 1'b1;
          k_cnt_d   = k_len;
          if (k_len == KW'(0)) begin
            state_d  = S_FLUSH;
            fl_cnt_d = FW'(NFL);
          end else begin
            state_d  = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (beat_s) begin
          k_cnt_d = k_cnt_q - KW'(1);
          if (k_cnt_q == KW'(1)) begin
            state_d  = S_FLUSH;
            fl_cnt_d = FW'(NFL);
          end else begin
            state_d  = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        fl_cnt_d = fl_cnt_q - FW'(1);
        if (fl_cnt_q == FW'(1)) begin
          state_d   = S_DRAIN;
          out_row_d = '0;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (out_row_q == RW'(ROWS-1)) begin
            state_d   = S_IDLE;
            out_row_d = '0;
            done_d    = 1'b1;
          end else begin
            out_row_d = out_row_q + RW'(1);
          end
        end else begin
          out_row_d = out_row_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Present the selected, frozen accumulator row while draining.
  always_comb begin
    out_data = '0;
    if (state_q == S_DRAIN) begin
      for (int c = 0; c < COLS; c++) begin
        out_data[c*ACC_W +: ACC_W] = acc_q[out_row_q][c];
      end
    end else begin
      out_data = '0;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q != S_IDLE);
  assign out_row   = out_row_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_array_os.sv
// Bench for systolic_array_os: a 2x2 and a 4x3 instance share one operand
// stream; each has its own expected-row queue filled from a reference model.
module tb_systolic_array_os;
  localparam int W = 8, ACC_W = 16, KW = 8, KMAX = 32;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic [KW-1:0] k_len;
  logic [31:0] a_in;
  logic [23:0] b_in;
  logic in_ready0, ov0, busy0, done0;
  logic [31:0] od0;
  logic [0:0]  orow0;
  logic in_ready1, ov1, busy1, done1;
  logic [47:0] od1;
  logic [1:0]  orow1;

  always #5 clk = ~clk;

  systolic_array_os #(.ROWS(2), .COLS(2), .W(W), .ACC_W(ACC_W), .KW(KW)) u_dut22 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready0), .a_in(a_in[15:0]), .b_in(b_in[15:0]), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0), .out_row(orow0), .busy(busy0), .done(done0));

  systolic_array_os #(.ROWS(4), .COLS(3), .W(W), .ACC_W(ACC_W), .KW(KW)) u_dut43 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready1), .a_in(a_in), .b_in(b_in), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .out_row(orow1), .busy(busy1), .done(done1));

  typedef struct packed {
    logic [1:0]  row;
    logic [47:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   am [4][KMAX];
  int   bm [KMAX][3];
  int   n_cmp = 0, n_bad = 0;
  int   ncyc = 0, beat_ncyc = 0;
  bit   has_beat = 1'b0, stall_mode = 1'b0;
  bit   seen_ov [2];
  int   done_cnt [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sequential k-order accumulation with wrap or sticky saturation.
  task automatic push_expected(input int k);
    exp_t e;
    logic signed [ACC_W-1:0] acc;
    bit sat;
    int p, full;
    for (int r = 0; r < 4; r++) begin
      e.row  = 2'(r);
      e.data = '0;
      for (int c = 0; c < 3; c++) begin
        acc = '0;
        sat = 1'b0;
        for (int kk = 0; kk < k; kk++) begin
          p = am[r][kk] * bm[kk][c];
`ifdef SYSTOLIC_SAT_EN
          if (!sat) begin
            full = int'(acc) + p;
            if (full > 32767) begin acc = 16'sh7fff; sat = 1'b1; end
            else if (full < -32768) begin acc = 16'sh8000; sat = 1'b1; end
            else acc = 16'(full);
          end
`else
          full = int'(acc) + p;
          acc  = 16'(full);
`endif
        end
        e.data[c*16 +: 16] = acc;
      end
      q1.push_back(e);
      if (r < 2) begin
        e.data[47:32] = '0;
        q0.push_back(e);
      end
    end
  endtask

  // Output-side generator for out_ready (3 low / 1 high when stalling).
  initial begin
    int oc;
    oc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = stall_mode ? (oc % 4 == 3) : 1'b1;
      oc++;
    end
  end

  // Monitor: sampled at the falling edge, away from the active edge.
  initial begin
    bit   prev_stall [2];
    logic [47:0] prev_od [2];
    logic [1:0]  prev_row [2];
    logic v, dn;
    logic [47:0] od;
    logic [1:0] orow;
    int nc, nr;
    exp_t e;
    prev_stall = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        prev_stall = '{1'b0, 1'b0};
      end else begin
        if (in_valid && in_ready1) beat_ncyc = ncyc;
        for (int d = 0; d < 2; d++) begin
          v    = (d == 0) ? ov0 : ov1;
          dn   = (d == 0) ? done0 : done1;
          od   = (d == 0) ? {16'h0, od0} : od1;
          orow = (d == 0) ? {1'b0, orow0} : orow1;
          nc   = (d == 0) ? 2 : 3;
          nr   = (d == 0) ? 2 : 4;
          if (dn) done_cnt[d]++;
          if (v) begin
            if (!seen_ov[d]) begin
              seen_ov[d] = 1'b1;
              if (has_beat) chk($sformatf("latency_d%0d", d), ncyc - beat_ncyc, nr + nc);
            end
            if (prev_stall[d]) begin
              chk($sformatf("hold_data_d%0d", d), od, prev_od[d]);
              chk($sformatf("hold_row_d%0d", d), orow, prev_row[d]);
            end
            if (out_ready) begin
              chk($sformatf("row_expected_d%0d", d), (d == 0) ? (q0.size() > 0) : (q1.size() > 0), 1);
              if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("row_idx_d%0d", d), orow, e.row);
                for (int c = 0; c < nc; c++)
                  chk($sformatf("C_d%0d_r%0d_c%0d", d, e.row, c), od[c*16 +: 16], e.data[c*16 +: 16]);
              end
            end
            prev_stall[d] = !out_ready;
            prev_od[d]    = od;
            prev_row[d]   = orow;
          end else begin
            prev_stall[d] = 1'b0;
          end
        end
      end
    end
  end

  task automatic run_job(input int k, input bit bubble, input bit poke);
    int idx, guard;
    bit poked;
    logic [3:0] pat;
    pat = 4'b1001;
    push_expected(k);
    has_beat = (k > 0);
    seen_ov  = '{1'b0, 1'b0};
    done_cnt = '{0, 0};
    @(posedge clk); #2;
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk); #2;
    start = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < k && guard < 400) begin
      in_valid = bubble ? pat[guard % 4] : 1'b1;
      for (int r = 0; r < 4; r++) a_in[r*8 +: 8] = 8'(am[r][idx]);
      for (int c = 0; c < 3; c++) b_in[c*8 +: 8] = 8'(bm[idx][c]);
      if (in_valid && in_ready1) idx++;
      @(posedge clk); #2;
      guard++;
    end
    in_valid = 1'b0;
    chk("beats_taken", idx, k);
    guard = 0;
    poked = 1'b0;
    while ((done_cnt[0] == 0 || done_cnt[1] == 0) && guard < 400) begin
      if (poke && !poked && ov0) begin
        start = 1'b1;
        k_len = 8'd5;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #2;
      guard++;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("done_pulse_d0", done_cnt[0], 1);
    chk("done_pulse_d1", done_cnt[1], 1);
    chk("queues_drained", q0.size() + q1.size(), 0);
    chk("idle_after_job", {busy0, busy1}, 2'b00);
    if (poke) chk("start_poked_in_drain", poked, 1);
  endtask

  task automatic fill_const(input int a, input int b, input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int r = 0; r < 4; r++) am[r][kk] = a;
      for (int c = 0; c < 3; c++) bm[kk][c] = b;
    end
  endtask

  task automatic fill_rand(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int r = 0; r < 4; r++) am[r][kk] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < 3; c++) bm[kk][c] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic fill_basic();
    am[0][0] = 1;  am[0][1] = 2;
    am[1][0] = 3;  am[1][1] = 4;
    am[2][0] = -5; am[2][1] = 6;
    am[3][0] = 7;  am[3][1] = -8;
    bm[0][0] = 5;  bm[0][1] = 6;  bm[0][2] = -3;
    bm[1][0] = 7;  bm[1][1] = 8;  bm[1][2] = 2;
  endtask

  // Start a job, feed a few beats, then reset asynchronously mid-LOAD.
  task automatic abort_job();
    int n;
    @(posedge clk); #2;
    start = 1'b1;
    k_len = 8'd5;
    @(posedge clk); #2;
    start = 1'b0;
    n = int'($urandom_range(1, 4));
    repeat (n) begin
      in_valid = 1'b1;
      a_in = $urandom;
      b_in = 24'($urandom);
      @(posedge clk); #2;
    end
    #1 rst = 1'b1;
    #1;
    chk("abort_in_ready", {in_ready0, in_ready1}, 2'b00);
    chk("abort_busy", {busy0, busy1}, 2'b00);
    chk("abort_out_valid", {ov0, ov1}, 2'b00);
    chk("abort_out_data", od1, 48'h0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    k_len = '0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", {in_ready0, in_ready1}, 2'b00);
    chk("rst_out_valid", {ov0, ov1}, 2'b00);
    chk("rst_busy", {busy0, busy1}, 2'b00);
    chk("rst_done", {done0, done1}, 2'b00);
    chk("rst_out_row", {orow0, orow1}, 3'b000);
    chk("rst_out_data0", od0, 32'h0);
    chk("rst_out_data1", od1, 48'h0);
    rst = 1'b0;

    fill_basic();
    run_job(2, 1'b0, 1'b0);

    stall_mode = 1'b1;
    run_job(2, 1'b1, 1'b1);
    stall_mode = 1'b0;

    fill_const(127, 127, 3);
    run_job(3, 1'b0, 1'b0);
    fill_const(-128, 127, 3);
    run_job(3, 1'b0, 1'b0);

    run_job(0, 1'b0, 1'b0);

    abort_job();
    fill_rand(17);
    run_job(17, 1'b0, 1'b0);

    stall_mode = 1'b1;
    fill_rand(17);
    run_job(17, 1'b1, 1'b0);
    stall_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
